// File: rtl/fp_sum4_pkg.sv
// Shared types and constants for the four-input FP adder operand gatherer.
package fp_sum4_pkg;

  typedef enum logic {StFill, StHold} state_e;

  localparam int unsigned RndWidth   = 3;
  localparam int unsigned CountWidth = 3;
  // +0.0 in every IEEE format is all-zero bits; sliced to the operand width.
  localparam logic [63:0] PadZero    = 64'h0;

endpackage

// File: rtl/fp_sum4_out_reg.sv
// Output holding register for a packed operand group, with valid/ready handshake.
module fp_sum4_out_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  output logic             free
);

  assign free = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_sum4_gather.sv
// Packs a stream of FP operands into groups of four for the sum4 adder stage.
// Optional transfer counter output grp_cnt when FP_SUM4_GATHER_CNT_EN is defined.
module fp_sum4_gather
  import fp_sum4_pkg::*;
#(
  parameter int unsigned sig_width       = 23,
  parameter int unsigned exp_width       = 8,
  parameter int unsigned ieee_compliance = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [sig_width+exp_width:0]        in_data,
  input  logic                                in_last,
  input  logic [RndWidth-1:0]                 in_rnd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [sig_width+exp_width:0]        out_a,
  output logic [sig_width+exp_width:0]        out_b,
  output logic [sig_width+exp_width:0]        out_c,
  output logic [sig_width+exp_width:0]        out_d,
  output logic [RndWidth-1:0]                 out_rnd,
  output logic [CountWidth-1:0]               out_count,
  output logic                                out_last
`ifdef FP_SUM4_GATHER_CNT_EN
  ,
  output logic [31:0]                         grp_cnt
`endif
);

  localparam int unsigned W    = sig_width + exp_width + 1;
  localparam int unsigned GrpW = 4 * W + RndWidth + CountWidth + 1;
  // Padding is +0.0 regardless of compliance mode.
  localparam logic [W-1:0] PadWord = (ieee_compliance != 0) ? PadZero[W-1:0] : PadZero[W-1:0];

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [W-1:0]          slot_q [4];
  logic [W-1:0]          slot_d [4];
  logic [RndWidth-1:0]   rnd_q, rnd_d;
  logic [CountWidth-1:0] hold_count_q, hold_count_d;
  logic                  hold_last_q, hold_last_d;

  logic [W-1:0]          grp [4];
  logic [RndWidth-1:0]   grp_rnd;
  logic [CountWidth-1:0] grp_count;
  logic                  accept, complete, load, free;
  logic [GrpW-1:0]       load_data, out_data;

  assign in_ready  = (state_q == StFill);
  assign accept    = in_valid & in_ready;
  assign complete  = accept & ((cnt_q == 2'd3) | in_last);
  assign grp_rnd   = (cnt_q == 2'd0) ? in_rnd : rnd_q;
  assign grp_count = {1'b0, cnt_q} + 3'd1;

  // Group as it would look if the current operand completes it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (i < int'(cnt_q)) begin
        grp[i] = slot_q[i];
      end else if (i == int'(cnt_q)) begin
        grp[i] = in_data;
      end else begin
        grp[i] = PadWord;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    rnd_d        = rnd_q;
    hold_count_d = hold_count_q;
    hold_last_d  = hold_last_q;
    load         = 1'b0;
    load_data    = {grp[0], grp[1], grp[2], grp[3], grp_rnd, grp_count, in_last};
    unique case (state_q)
      StFill: begin
        if (complete) begin
          cnt_d = 2'd0;
          if (free) begin
            load = 1'b1;
          end else begin
            slot_d       = grp;
            rnd_d        = grp_rnd;
            hold_count_d = grp_count;
            hold_last_d  = in_last;
            state_d      = StHold;
          end
        end else if (accept) begin
          slot_d[cnt_q] = in_data;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd0) rnd_d = in_rnd;
        end
      end
      StHold: begin
        load_data = {slot_q[0], slot_q[1], slot_q[2], slot_q[3], rnd_q, hold_count_q,
                     hold_last_q};
        if (free) begin
          load    = 1'b1;
          state_d = StFill;
          cnt_d   = 2'd0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      cnt_q        <= 2'd0;
      slot_q       <= '{default: '0};
      rnd_q        <= '0;
      hold_count_q <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      rnd_q        <= rnd_d;
      hold_count_q <= hold_count_d;
      hold_last_q  <= hold_last_d;
    end
  end

  fp_sum4_out_reg #(
    .Width(GrpW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .free     (free)
  );

  assign {out_a, out_b, out_c, out_d, out_rnd, out_count, out_last} = out_data;

`ifdef FP_SUM4_GATHER_CNT_EN
  logic [31:0] grp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_cnt_q <= '0;
    end else if (out_valid && out_ready && grp_cnt_q != 32'hFFFF_FFFF) begin
      grp_cnt_q <= grp_cnt_q + 32'd1;
    end
  end

  assign grp_cnt = grp_cnt_q;
`endif

endmodule

// File: tb/tb_fp_sum4_gather.sv
// Directed, table-driven bench for fp_sum4_gather (single precision).
module tb_fp_sum4_gather;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_rnd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_c, out_d;
  logic [2:0]  out_rnd;
  logic [2:0]  out_count;
  logic        out_last;
`ifdef FP_SUM4_GATHER_CNT_EN
  logic [31:0] grp_cnt;
`endif

  always #5 clk = ~clk;

  fp_sum4_gather #(
    .sig_width      (23),
    .exp_width      (8),
    .ieee_compliance(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_rnd   (in_rnd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_c    (out_c),
    .out_d    (out_d),
    .out_rnd  (out_rnd),
    .out_count(out_count),
    .out_last (out_last)
`ifdef FP_SUM4_GATHER_CNT_EN
    ,
    .grp_cnt  (grp_cnt)
`endif
  );

  typedef struct {
    logic [31:0] a, b, c, d;
    logic [2:0]  rnd;
    logic [2:0]  count;
    logic        last;
  } grp_t;

  typedef struct {
    int          n;
    logic        last;
    logic [31:0] op [4];
    logic [2:0]  rnd0;
    logic [2:0]  rnd_rest;
    grp_t        exp_grp;
  } vec_t;

  grp_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stalls   = 0;
  vec_t vecs [6];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back('{a: out_a, b: out_b, c: out_c, d: out_d, rnd: out_rnd,
                        count: out_count, last: out_last});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_grp(input string name, input grp_t g, input grp_t e);
    check({name, ".a"}, g.a, e.a);
    check({name, ".b"}, g.b, e.b);
    check({name, ".c"}, g.c, e.c);
    check({name, ".d"}, g.d, e.d);
    check({name, ".rnd"}, {29'd0, g.rnd}, {29'd0, e.rnd});
    check({name, ".count"}, {29'd0, g.count}, {29'd0, e.count});
    check({name, ".last"}, {31'd0, g.last}, {31'd0, e.last});
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_op(input logic [31:0] data, input logic last, input logic [2:0] rnd);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    in_rnd   = rnd;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 60) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, expected 1", waits);
        break;
      end
    end
    stalls += waits;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_groups(input int n);
    for (int i = 0; i < 50; i++) begin
      if (got_q.size() >= n) break;
      @(posedge clk);
    end
    #1;
    check("group_count_seen", got_q.size(), n);
  endtask

  function automatic vec_t mk(input int n, input logic last, input logic [31:0] o0,
                              input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] o3, input logic [2:0] r0,
                              input logic [2:0] rr, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [2:0] erd,
                              input logic [2:0] ecnt, input logic elast);
    vec_t v;
    v.n = n;
    v.last = last;
    v.op[0] = o0; v.op[1] = o1; v.op[2] = o2; v.op[3] = o3;
    v.rnd0 = r0;
    v.rnd_rest = rr;
    v.exp_grp = '{a: e0, b: e1, c: e2, d: e3, rnd: erd, count: ecnt, last: elast};
    return v;
  endfunction

  initial begin
    grp_t g, e;
    vecs[0] = mk(4, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 3'd0, 3'd0,
                 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 3'd0, 3'd4, 1'b0);
    vecs[1] = mk(4, 1'b1, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 3'd2, 3'd2,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 3'd2, 3'd4, 1'b1);
    vecs[2] = mk(2, 1'b1, 32'h40000000, 32'h40400000, 32'hDEADBEEF, 32'hDEADBEEF, 3'd5, 3'd6,
                 32'h40000000, 32'h40400000, 32'h0, 32'h0, 3'd5, 3'd2, 1'b1);
    vecs[3] = mk(1, 1'b1, 32'h7FC00000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'd7, 3'd0,
                 32'h7FC00000, 32'h0, 32'h0, 32'h0, 3'd7, 3'd1, 1'b1);
    vecs[4] = mk(3, 1'b1, 32'hFF800000, 32'h00000001, 32'h80000000, 32'hDEADBEEF, 3'd4, 3'd0,
                 32'hFF800000, 32'h00000001, 32'h80000000, 32'h0, 3'd4, 3'd3, 1'b1);
    vecs[5] = mk(4, 1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 3'd1, 3'd3,
                 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000, 3'd1, 3'd4, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_rnd = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    e = '{a: 0, b: 0, c: 0, d: 0, rnd: 0, count: 0, last: 0};
    g = '{a: out_a, b: out_b, c: out_c, d: out_d, rnd: out_rnd, count: out_count,
          last: out_last};
    check_grp("rst_outputs", g, e);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back stream of all table vectors with out_ready held high.
    stalls = 0;
    foreach (vecs[k]) begin
      for (int j = 0; j < vecs[k].n; j++)
        send_op(vecs[k].op[j], vecs[k].last && (j == vecs[k].n - 1),
                (j == 0) ? vecs[k].rnd0 : vecs[k].rnd_rest);
    end
    wait_groups(6);
    check("stream_no_stall", stalls, 0);
    foreach (vecs[k]) begin
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        check_grp($sformatf("vec%0d", k), g, vecs[k].exp_grp);
      end
    end
`ifdef FP_SUM4_GATHER_CNT_EN
    check("grp_cnt_table", grp_cnt, 32'd6);
`endif

    // Backpressure: group 1 parks in the output register, group 2 forces HOLD.
    out_ready = 1'b0;
    fork
      begin
        for (int j = 0; j < 12; j++) send_op(32'h1000 + j, 1'b0, 3'd0);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        check("hold_out_a", out_a, 32'h1000);
        check("hold_out_d", out_d, 32'h1003);
        out_ready = 1'b1;
      end
    join
    wait_groups(3);
    repeat (4) @(posedge clk);
    #1;
    check("drain_no_dup", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        e = '{a: 32'h1000 + 4 * k, b: 32'h1001 + 4 * k, c: 32'h1002 + 4 * k,
              d: 32'h1003 + 4 * k, rnd: 3'd0, count: 3'd4, last: 1'b0};
        check_grp($sformatf("drain%0d", k), g, e);
      end
    end

    // Reset mid-group discards the partial operands.
    send_op(32'hAAAA0001, 1'b0, 3'd2);
    send_op(32'hAAAA0002, 1'b0, 3'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_out_valid2", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) send_op(32'h3F800000 + j, 1'b0, 3'd3);
    wait_groups(1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_one_group", got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = '{a: 32'h3F800000, b: 32'h3F800001, c: 32'h3F800002, d: 32'h3F800003, rnd: 3'd3,
            count: 3'd4, last: 1'b0};
      check_grp("midrst", g, e);
    end

`ifdef FP_SUM4_GATHER_CNT_EN
    for (int k = 0; k < 4; k++) send_op(32'h5000 + k, 1'b1, 3'd0);
    wait_groups(4);
    repeat (2) @(posedge clk);
    #1;
    check("grp_cnt_five", grp_cnt, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sum4_gather.md
# fp_sum4_gather

Streaming operand gatherer that feeds the four-input floating-point adder stage (DW_fp_sum4 instance wrapper). Accepts one IEEE-754 operand per cycle over a valid/ready stream and packs consecutive operands into groups of four, presented in parallel as the adder's a/b/c/d inputs. A short final group, marked by `in_last`, is padded with +0.0. The block double-buffers: one group is gathered while the previous group waits for the downstream stage, sustaining one operand per cycle.

## Interface
- `sig_width`, 23, significand field width
- `exp_width`, 8, exponent field width
- `ieee_compliance`, 0, passed through for consistency with the adder; padding is +0.0 in both modes
- W denotes `sig_width+exp_width+1`
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: operand valid
- `in_ready` output 1: block accepts operand this cycle
- `in_data` input W: FP operand
- `in_last` input 1: operand closes the current group
- `in_rnd` input 3: rounding mode, sampled on the first operand of each group
- `out_valid` output 1: group valid
- `out_ready` input 1: downstream accepts group
- `out_a`, `out_b`, `out_c`, `out_d` output W each: slots 0..3 in arrival order
- `out_rnd` output 3: rounding mode for the group
- `out_count` output 3: real operands in group, 1..4
- `out_last` output 1: group was closed by `in_last`

## Operation
- Transfer on input when `in_valid & in_ready`; on output when `out_valid & out_ready`.
- Gather side: slot counter `cnt` 0..3, slot registers s0..s2, and a latched rnd.
- States: FILL (collecting) and HOLD (complete group blocked by an occupied output register).
- FILL, accepted operand with `cnt<3` and `in_last=0`: store in slot `cnt`; `cnt++`. On `cnt==0`, latch `in_rnd`.
- FILL, accepted operand with `cnt==3` or `in_last=1`: the group completes. The completing operand goes in slot `cnt`; slots above `cnt` are zero.
  - If the output register is free (`!out_valid | out_ready`), load it directly: `out_count=cnt+1`, `out_last=in_last`; `cnt` becomes 0.
  - Otherwise store the group and go to HOLD.
- HOLD: `in_ready=0`. When the output register frees, transfer the held group, return to FILL, and set `cnt=0`.
- `in_ready = (state==FILL)`. This is independent of `out_ready` in FILL; the only combinational input-to-output path is in HOLD.
- `in_last` with `cnt==0` produces a 1-operand group: `out_b/c/d = 0`, `out_count=1`.
- Output register holds all out_* stable while `out_valid & !out_ready`.
- No arithmetic is performed and operand bits pass untouched (NaN/Inf/denormals unchanged). An all-(-0) short group plus +0 padding sums to +0 under RNE; this is accepted behaviour.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_a..d=0`, `out_rnd=0`, `out_count=0`, `out_last=0`, `cnt=0`, state FILL.
- Latency: `out_valid` rises the cycle after the completing operand is accepted, when the output register is free.
- Throughput: 4 operands per group, one group every 4 cycles with `out_ready=1`, and no bubbles.
- Simultaneous group completion and output consumption: the new group loads and `out_valid` stays 1.
- Reset asserted mid-group or in HOLD discards all partial and held data; outputs return to reset values on the next edge.

## Configuration
- `FP_SUM4_GATHER_CNT_EN` defined:
  - Adds output `grp_cnt` [31:0], counting output transfers.
  - The counter saturates at 2^32-1 and resets to 0.
- `FP_SUM4_GATHER_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `fp_sum4_pkg` holds:
  - the state enum (FILL, HOLD)
  - the padding constant (all zeros)
  - the rnd width constant (3)
- One natural sub-module, `fp_sum4_out_reg`: the output holding register with its valid/ready logic. The gather counter and FSM stay in the top level.

## Test plan
- Feed 8 operands 1.0..8.0 (0x3F800000..0x41000000) with `out_ready=1`, `in_last` on the 8th. Expect:
  - two groups, {1,2,3,4} with count 4 and last 0, then {5,6,7,8} with count 4 and last 1;
  - `in_ready` held at 1 throughout.
- Feed 0x40000000, 0x40400000 with `in_last` on the second. Expect one group `a=0x40000000`, `b=0x40400000`, `c=d=0`, count 2, last 1.
- Hold `out_ready=0` and stream 12 operands:
  - first group sits in the output register;
  - the second group completes and `in_ready` drops (HOLD);
  - after `out_ready=1`, the groups drain in order with no loss or duplication.
- Give `in_rnd=1` on operand 0 and `in_rnd=3` on operands 1..3. Expect `out_rnd=1`.
- Assert `rst` after 2 operands of a group, then feed 4 new operands. Expect `out_valid=0` during reset, then exactly one group containing only the new operands.
- With `FP_SUM4_GATHER_CNT_EN` defined, send 5 groups. Expect `grp_cnt=5`.
